// File: rtl/cmp_sweep_checker.sv
// Sweeps all 16 (a,b) pairs of a 2-bit comparator, checks its one-hot
// red/green/blue response in a single sample cycle per vector and tallies mismatches.
//
// state  | meaning
// IDLE   | waiting for start, a=b=0
// DRIVE  | holding vector idx on a/b for HOLD_CYCLES-1 cycles
// SAMPLE | one cycle: compare response against expected
// FINISH | sweep done, result held until next start
module cmp_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] a,
  output logic [1:0] b,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_idx
);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 2..255");
  end

  // Counter is loaded with HOLD_CYCLES-2 so DRIVE lasts HOLD_CYCLES-1 cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_idx;
  logic [7:0] r_hold;
  logic [4:0] r_err;
  logic       r_fail_valid;
  logic [3:0] r_fail_idx;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;

  logic [3:0] w_idx_nxt;
  logic [7:0] w_hold_nxt;
  logic [4:0] w_err_nxt;
  logic       w_fail_valid_nxt;
  logic [3:0] w_fail_idx_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic       w_start_sweep;
  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [2:0] w_expected;
  logic       w_mismatch;

  assign w_a           = r_idx[3:2];
  assign w_b           = r_idx[1:0];
  assign w_expected    = {(w_a > w_b), (w_a == w_b), (w_a < w_b)};
  assign w_mismatch    = ({red, green, blue} != w_expected);
  assign w_start_sweep = start && ((r_state == ST_IDLE) || (r_state == ST_FINISH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_FINISH: if (start) w_state_nxt = ST_DRIVE;
      ST_DRIVE:           if (r_hold == 8'd0) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE:          w_state_nxt = (r_idx == 4'd15) ? ST_FINISH : ST_DRIVE;
      default:            w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_idx_nxt        = r_idx;
    w_hold_nxt       = r_hold;
    w_err_nxt        = r_err;
    w_fail_valid_nxt = r_fail_valid;
    w_fail_idx_nxt   = r_fail_idx;
    if (w_start_sweep) begin
      w_idx_nxt        = 4'd0;
      w_hold_nxt       = HOLD_LOAD;
      w_err_nxt        = 5'd0;
      w_fail_valid_nxt = 1'b0;
      w_fail_idx_nxt   = 4'd0;
    end else if (r_state == ST_DRIVE) begin
      if (r_hold != 8'd0) w_hold_nxt = r_hold - 8'd1;
    end else if (r_state == ST_SAMPLE) begin
      if (w_mismatch) begin
        w_err_nxt = r_err + 5'd1;
        if (!r_fail_valid) begin
          w_fail_valid_nxt = 1'b1;
          w_fail_idx_nxt   = r_idx;
        end
      end
      if (r_idx != 4'd15) begin
        w_idx_nxt  = r_idx + 4'd1;
        w_hold_nxt = HOLD_LOAD;
      end
    end
    w_busy_nxt = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);
    w_done_nxt = (w_state_nxt == ST_FINISH);
    w_pass_nxt = w_done_nxt && (w_err_nxt == 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= 4'd0;
      r_hold       <= 8'd0;
      r_err        <= 5'd0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_hold       <= w_hold_nxt;
      r_err        <= w_err_nxt;
      r_fail_valid <= w_fail_valid_nxt;
      r_fail_idx   <= w_fail_idx_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
    end
  end

  assign a          = w_a;
  assign b          = w_b;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Bench for cmp_sweep_checker: two instances (HOLD_CYCLES 4 and 2) driven by
// behavioural comparator models, with a sweep-level reference for the results.
module tb_cmp_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, start2;
  logic [1:0] a4, b4, a2, b2;
  logic       red4, green4, blue4, red2, green2, blue2;
  logic       busy4, done4, pass4, fv4, busy2, done2, pass2, fv2;
  logic [4:0] err4, err2;
  logic [3:0] fi4, fi2;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mode4   = 0;
  logic [15:0] bad_mask = '0;
  logic [2:0]  xr [16];
  logic [1:0]  a2_d, b2_d;
  logic [2:0]  junk2;
  bit          cur = 1'b0;

  cmp_sweep_checker #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .red(red4), .green(green4), .blue(blue4), .busy(busy4), .done(done4),
    .pass(pass4), .err_count(err4), .fail_valid(fv4), .fail_idx(fi4)
  );

  cmp_sweep_checker #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .red(red2), .green(green2), .blue(blue2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_valid(fv2), .fail_idx(fi2)
  );

  function automatic logic [2:0] ideal(logic [1:0] a, logic [1:0] b);
    return {(a > b), (a == b), (a < b)};
  endfunction

  // 0 correct, 1 green stuck low, 2 red/blue swapped, 3 random corruption per vector
  function automatic logic [2:0] resp(int mode, logic [1:0] a, logic [1:0] b, logic bad, logic [2:0] x);
    logic [2:0] e;
    e = ideal(a, b);
    case (mode)
      1:       return e & 3'b101;
      2:       return {e[0], e[1], e[2]};
      3:       return bad ? (e ^ x) : e;
      default: return e;
    endcase
  endfunction

  assign {red4, green4, blue4} = resp(mode4, a4, b4, bad_mask[{a4, b4}], xr[{a4, b4}]);

  // Slow comparator: wrong (random) in the first cycle after a/b change, correct afterwards.
  always @(posedge clk) begin
    a2_d  <= a2;
    b2_d  <= b2;
    junk2 <= 3'($urandom_range(1, 7));
  end
  assign {red2, green2, blue2} = ((a2 == a2_d) && (b2 == b2_d)) ? ideal(a2, b2) : (ideal(a2, b2) ^ junk2);

  logic       m_busy, m_done, m_pass, m_fv;
  logic [1:0] m_a, m_b;
  logic [4:0] m_err;
  logic [3:0] m_fi;
  assign m_busy = cur ? busy2 : busy4;
  assign m_done = cur ? done2 : done4;
  assign m_pass = cur ? pass2 : pass4;
  assign m_fv   = cur ? fv2   : fv4;
  assign m_a    = cur ? a2    : a4;
  assign m_b    = cur ? b2    : b4;
  assign m_err  = cur ? err2  : err4;
  assign m_fi   = cur ? fi2   : fi4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected result of the first `upto` vectors under a comparator mode.
  task automatic ref_model(input int mode, input int upto, output int e_err, output int e_fi);
    logic [3:0] v;
    e_err = 0;
    e_fi  = 0;
    for (int i = 0; i < upto; i++) begin
      v = 4'(i);
      if (resp(mode, v[3:2], v[1:0], bad_mask[v], xr[v]) != ideal(v[3:2], v[1:0])) begin
        if (e_err == 0) e_fi = i;
        e_err++;
      end
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start2 = v;
    else     start4 = v;
  endtask

  task automatic sweep(input bit sel, input int h, input int mode, input int ign1, input int ign2, input string tag);
    int e_err, e_fi, vec;
    cur = sel;
    ref_model(mode, 16, e_err, e_fi);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 16 * h; c++) begin
      vec = c / h;
      check($sformatf("%s busy c%0d", tag, c), 32'(m_busy), 1);
      check($sformatf("%s done c%0d", tag, c), 32'(m_done), 0);
      check($sformatf("%s a c%0d", tag, c), 32'(m_a), 32'(vec / 4));
      check($sformatf("%s b c%0d", tag, c), 32'(m_b), 32'(vec % 4));
      set_start(sel, (c == ign1) || (c == ign2));
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    check({tag, " done"}, 32'(m_done), 1);
    check({tag, " busy end"}, 32'(m_busy), 0);
    check({tag, " a end"}, 32'(m_a), 3);
    check({tag, " b end"}, 32'(m_b), 3);
    check({tag, " err_count"}, 32'(m_err), 32'(e_err));
    check({tag, " pass"}, 32'(m_pass), 32'(e_err == 0));
    check({tag, " fail_valid"}, 32'(m_fv), 32'(e_err != 0));
    check({tag, " fail_idx"}, 32'(m_fi), 32'(e_fi));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " a"}, 32'(a4), 0);
    check({tag, " b"}, 32'(b4), 0);
    check({tag, " busy"}, 32'(busy4), 0);
    check({tag, " done"}, 32'(done4), 0);
    check({tag, " pass"}, 32'(pass4), 0);
    check({tag, " err"}, 32'(err4), 0);
    check({tag, " fv"}, 32'(fv4), 0);
    check({tag, " fi"}, 32'(fi4), 0);
  endtask

  initial begin
    int e_err, e_fi;
    rst_n  = 1'b0;
    start4 = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) xr[i] = 3'd1;
    #2;
    check_reset_vals("por");
    check("por busy2", 32'(busy2), 0);
    check("por done2", 32'(done2), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy", 32'(busy4), 0);

    mode4 = 0;
    sweep(0, 4, 0, -1, -1, "correct");
    mode4 = 1;
    sweep(0, 4, 1, -1, -1, "green_stuck");
    mode4 = 2;
    sweep(0, 4, 2, 10, 30, "swap_ign");
    for (int r = 0; r < 3; r++) begin
      bad_mask = 16'($urandom);
      for (int i = 0; i < 16; i++) xr[i] = 3'($urandom_range(1, 7));
      mode4 = 3;
      sweep(0, 4, 3, -1, -1, $sformatf("rand%0d", r));
    end
    mode4 = 0;
    sweep(0, 4, 0, -1, -1, "restart");

    // Reset in the middle of vector 7 with some failures already recorded.
    mode4 = 1;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (29) @(negedge clk);
    ref_model(1, 7, e_err, e_fi);
    check("pre_rst err", 32'(err4), 32'(e_err));
    check("pre_rst a", 32'(a4), 1);
    check("pre_rst b", 32'(b4), 3);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst busy", 32'(busy4), 0);
    check("post_rst done", 32'(done4), 0);
    check("post_rst a", 32'(a4), 0);
    check("post_rst err", 32'(err4), 0);
    mode4 = 0;
    sweep(0, 4, 0, -1, -1, "after_rst");

    sweep(1, 2, 0, -1, -1, "slow_cmp");
    sweep(1, 2, 0, 5, -1, "slow_cmp2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_sweep_checker.md
CMP_SWEEP_CHECKER -- requirements
Module: cmp_sweep_checker

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, is the number of clock cycles each vector is driven; legal range is 2..255.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  is an asynchronous, active-low reset.
REQ-004 start  input  1  is a single-cycle run request.
REQ-005 a  output  2  is the comparator operand A, driven to the device under check.
REQ-006 b  output  2  is the comparator operand B, driven to the device under check.
REQ-007 red  input  1  is the comparator result "A greater than B".
REQ-008 green  input  1  is the comparator result "A equal to B".
REQ-009 blue  input  1  is the comparator result "A less than B".
REQ-010 busy  output  1  is high while a sweep is in progress.
REQ-011 done  output  1  is high once a sweep has completed, until the next start.
REQ-012 pass  output  1  is valid when done=1; it is 1 iff err_count==0.
REQ-013 err_count  output  5  is the number of mismatching vectors in the current or last sweep.
REQ-014 fail_valid  output  1  indicates that fail_idx holds a captured failure.
REQ-015 fail_idx  output  4  is the index of the first failing vector.

Function
REQ-016 The FSM shall have the states IDLE, DRIVE, SAMPLE and FINISH.
REQ-017 Vector index idx (4 bits) shall run 0..15, with a=idx[3:2] and b=idx[1:0].
REQ-018 Expected response shall be one-hot: red=1 iff a>b, green=1 iff a==b, blue=1 iff a<b, all unsigned.
REQ-019 A vector is a mismatch when {red,green,blue} differs from the expected value in any bit; zero-hot and multi-hot responses are mismatches.
REQ-020 IDLE behaviour: a=b=0, busy=0, and start=1 moves to DRIVE with idx=0.
REQ-021 On the IDLE-to-DRIVE transition, err_count, fail_valid and fail_idx shall clear to 0.
REQ-022 DRIVE shall hold a/b for HOLD_CYCLES-1 cycles, counted by an 8-bit hold counter, then move to SAMPLE.
REQ-023 SAMPLE shall last one cycle, during which a/b stay stable and the inputs are compared.
  - On mismatch, err_count increments by 1; the maximum is 16, so no overflow occurs.
  - On the first mismatch, fail_idx=idx and fail_valid=1; later mismatches leave both unchanged.
REQ-024 After SAMPLE: if idx<15, idx increments and the FSM returns to DRIVE; if idx==15, the FSM moves to FINISH.
REQ-025 Each vector shall be driven for exactly HOLD_CYCLES cycles.
  - Vector 0 appears on a/b in the cycle after start is sampled.
  - done rises exactly 16*HOLD_CYCLES+1 cycles after the start edge.
REQ-026 busy=1 in DRIVE and SAMPLE; busy=0 in IDLE and FINISH.
REQ-027 FINISH behaviour: done=1, pass=(err_count==0), and a/b hold the last vector (3,3).
REQ-028 start=1 in FINISH shall begin a new sweep exactly as from IDLE, and done shall drop in the same cycle that busy rises.
REQ-029 start while busy=1 shall be ignored, with no restart and no effect on counters.
REQ-030 The red/green/blue inputs shall be sampled only in SAMPLE; their values in DRIVE shall not affect any output.
REQ-031 All outputs shall be registered.

Reset
REQ-032 When rst_n=0, the block shall go immediately, without waiting for clk, to IDLE with:
  - a=0, b=0, busy=0, done=0, pass=0;
  - err_count=0, fail_valid=0, fail_idx=0;
  - idx=0 and hold counter=0.
REQ-033 Reset asserted mid-sweep shall abort the sweep with no partial result retained.
  - After rst_n rises, the block stays in IDLE until start.

Verification
REQ-034 Correct comparator model, HOLD_CYCLES=4, start pulse -> busy=1 for 64 cycles, a/b step through 0..15, and done=1 at cycle 65 with pass=1, err_count=0 and fail_valid=0.
REQ-035 Model with green stuck at 0 -> err_count=4, pass=0, fail_valid=1 and fail_idx=0 (vectors 0, 5, 10 and 15 fail).
REQ-036 Model that returns red and blue swapped -> err_count=12 and fail_idx=1.
REQ-037 Start pulses at cycles 10 and 30 of a sweep -> both are ignored and done timing is unchanged; a start in FINISH -> the counters clear and a new sweep runs.
REQ-038 rst_n pulsed low during vector 7 -> all outputs reach reset values asynchronously and the block stays in IDLE until start; a following sweep gives pass=1.
REQ-039 HOLD_CYCLES=2, with a comparator response that becomes correct only 1 cycle after a/b change -> pass=1, confirming that only the SAMPLE cycle is checked.
